// File: rtl/multi_channel_data_synchronizer.sv
// Multi-channel valid/data synchronizer: per-channel valid CDC with edge detect, holding
// registers and a round-robin output stage. Define DATA_SYNC_OVERRUN_DETECT_EN for sticky overrun flags.
module multi_channel_data_synchronizer #(
  parameter int STAGE_COUNT   = 2,
  parameter int BUS_WIDTH     = 8,
  parameter int CHANNEL_COUNT = 4,
  parameter int TOGGLE_MODE   = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [CHANNEL_COUNT-1:0]           asynchronous_data_valid,
  input  logic [CHANNEL_COUNT*BUS_WIDTH-1:0] asynchronous_data,
  input  logic                               synchronous_ready,
  input  logic [CHANNEL_COUNT-1:0]           overrun_clear,
  output logic                               synchronous_data_valid,
  output logic [BUS_WIDTH-1:0]               synchronous_data,
  output logic [$clog2(CHANNEL_COUNT)-1:0]   synchronous_channel,
  output logic [CHANNEL_COUNT-1:0]           pending,
  output logic [CHANNEL_COUNT-1:0]           overrun
);

  localparam int CH_W = $clog2(CHANNEL_COUNT);
  localparam int IW   = CH_W + 1;

  typedef logic [CHANNEL_COUNT-1:0] ch_vec_t;

  ch_vec_t              sync_q [STAGE_COUNT];
  ch_vec_t              hist_q;
  ch_vec_t              synced;
  ch_vec_t              event_vec;
  ch_vec_t              grant_vec;
  logic [BUS_WIDTH-1:0] hold_q [CHANNEL_COUNT];
  logic [CH_W-1:0]      rr_ptr;
  logic [CH_W-1:0]      grant_idx;
  logic [CH_W-1:0]      search_ch;
  logic [IW-1:0]        search_idx;
  logic                 grant_valid;
  logic                 load;
  logic                 grant_fire;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < STAGE_COUNT; s++) sync_q[s] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= asynchronous_data_valid;
      for (int s = 1; s < STAGE_COUNT; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= synced;
    end
  end

  assign synced    = sync_q[STAGE_COUNT-1];
  assign event_vec = (TOGGLE_MODE != 0) ? (synced ^ hist_q) : (synced & ~hist_q);

  assign load       = !synchronous_data_valid || synchronous_ready;
  assign grant_fire = load && grant_valid;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    search_idx  = '0;
    search_ch   = '0;
    grant_vec   = '0;
    for (int k = 0; k < CHANNEL_COUNT; k++) begin
      search_idx = {1'b0, rr_ptr} + IW'(k);
      if (search_idx >= IW'(CHANNEL_COUNT)) search_idx = search_idx - IW'(CHANNEL_COUNT);
      search_ch = search_idx[CH_W-1:0];
      if (!grant_valid && pending[search_ch]) begin
        grant_valid = 1'b1;
        grant_idx   = search_ch;
      end
    end
    if (grant_fire) grant_vec[grant_idx] = 1'b1;
  end

  // NOTE: holding registers are reset explicitly so a reset discards every in-flight word.
  // An event on the channel being granted still wins pending: the old word leaves, the new one stays.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNEL_COUNT; c++) hold_q[c] <= '0;
      pending <= '0;
    end else begin
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        if (event_vec[c]) begin
          hold_q[c]  <= asynchronous_data[c*BUS_WIDTH +: BUS_WIDTH];
          pending[c] <= 1'b1;
        end else if (grant_vec[c]) begin
          pending[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      synchronous_data_valid <= 1'b0;
      synchronous_data       <= '0;
      synchronous_channel    <= '0;
      rr_ptr                 <= '0;
    end else if (load) begin
      synchronous_data_valid <= grant_valid;
      if (grant_valid) begin
        synchronous_data    <= hold_q[grant_idx];
        synchronous_channel <= grant_idx;
        rr_ptr              <= (grant_idx == CH_W'(CHANNEL_COUNT - 1)) ? '0 : grant_idx + CH_W'(1);
      end
    end
  end

`ifdef DATA_SYNC_OVERRUN_DETECT_EN
  ch_vec_t overwrite;
  assign overwrite = event_vec & pending & ~grant_vec;

  // Set has priority over a coincident clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overrun <= '0;
    else        overrun <= overwrite | (overrun & ~overrun_clear);
  end
`else
  logic unused_clear;
  assign unused_clear = ^overrun_clear;
  assign overrun      = '0;
`endif

endmodule

// File: tb/tb_multi_channel_data_synchronizer.sv
// Self-checking bench: directed vectors, a toggle-mode instance and randomized traffic
// compared against a queue/array reference model of the channel/arbiter behaviour.
module tb_multi_channel_data_synchronizer;

  localparam int N      = 4;
  localparam int W      = 8;
  localparam int STAGES = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] avalid = '0;
  logic [N*W-1:0] adata = '0;
  logic         ready = 1'b1;
  logic [N-1:0] oclear = '0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_ch;
  logic [N-1:0] out_pend;
  logic [N-1:0] out_ovr;

  logic [N-1:0]   t_valid = '0;
  logic [N*W-1:0] t_data = '0;
  logic           t_out_valid;
  logic [W-1:0]   t_out_data;
  logic [1:0]     t_out_ch;
  logic [N-1:0]   t_pend;
  logic [N-1:0]   t_ovr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_channel_data_synchronizer #(
    .STAGE_COUNT(STAGES), .BUS_WIDTH(W), .CHANNEL_COUNT(N), .TOGGLE_MODE(0)
  ) dut (
    .clk(clk), .reset(reset),
    .asynchronous_data_valid(avalid), .asynchronous_data(adata),
    .synchronous_ready(ready), .overrun_clear(oclear),
    .synchronous_data_valid(out_valid), .synchronous_data(out_data),
    .synchronous_channel(out_ch), .pending(out_pend), .overrun(out_ovr)
  );

  multi_channel_data_synchronizer #(
    .STAGE_COUNT(STAGES), .BUS_WIDTH(W), .CHANNEL_COUNT(N), .TOGGLE_MODE(1)
  ) dut_t (
    .clk(clk), .reset(reset),
    .asynchronous_data_valid(t_valid), .asynchronous_data(t_data),
    .synchronous_ready(1'b1), .overrun_clear('0),
    .synchronous_data_valid(t_out_valid), .synchronous_data(t_out_data),
    .synchronous_channel(t_out_ch), .pending(t_pend), .overrun(t_ovr)
  );

`ifdef DATA_SYNC_OVERRUN_DETECT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  // Reference model: samples of the input valids, per-channel held words, pending set,
  // output word, and the channel the round-robin search starts from.
  logic [N-1:0] samples[$];
  logic [W-1:0] m_hold[N];
  logic [N-1:0] m_pend;
  logic [N-1:0] m_ovr;
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_ch;
  int           m_ptr;

  task automatic model_reset();
    samples.delete();
    for (int j = 0; j <= STAGES; j++) samples.push_front('0);
    for (int c = 0; c < N; c++) m_hold[c] = '0;
    m_pend = '0; m_ovr = '0; m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] now_sync, before_sync, ev;
    bit found;
    int g;
    if (!reset) begin
      model_reset();
      return;
    end
    // A valid seen at the pins shows up as an event STAGES edges later.
    now_sync    = samples[STAGES-1];
    before_sync = samples[STAGES];
    ev = now_sync & ~before_sync;
    found = 1'b0; g = 0;
    if (!m_valid || ready) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!found && m_pend[c]) begin found = 1'b1; g = c; end
      end
      m_valid = found;
      if (found) begin
        m_data = m_hold[g]; m_ch = g; m_ptr = (g + 1) % N; m_pend[g] = 1'b0;
      end
    end
    for (int c = 0; c < N; c++) begin
      if (ev[c] && m_pend[c] && OVR_EN) m_ovr[c] = 1'b1;
      else if (oclear[c])               m_ovr[c] = 1'b0;
      if (ev[c]) begin
        m_hold[c] = adata[c*W +: W];
        m_pend[c] = 1'b1;
      end
    end
    samples.push_front(avalid);
    void'(samples.pop_back());
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin tick(); n++; end
    check(name, 32'(out_valid), 32'd1);
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] d, input logic v);
    adata[ch*W +: W] = d;
    avalid[ch] = v;
  endtask

  typedef struct {
    int           ch;
    logic [W-1:0] data;
    logic [N-1:0] exp_pend;
    logic [1:0]   exp_ch;
    logic [W-1:0] exp_data;
  } vec_t;

  initial begin
    vec_t vecs[4];
    logic [W-1:0] words[$];
    logic [1:0]   wch[$];
    logic [W-1:0] w0, w1;
    logic [1:0]   c0, c1;

    vecs[0] = '{ch: 2, data: 8'hA5, exp_pend: 4'b0100, exp_ch: 2'd2, exp_data: 8'hA5};
    vecs[1] = '{ch: 1, data: 8'hC3, exp_pend: 4'b0010, exp_ch: 2'd1, exp_data: 8'hC3};
    vecs[2] = '{ch: 3, data: 8'h5F, exp_pend: 4'b1000, exp_ch: 2'd3, exp_data: 8'h5F};
    vecs[3] = '{ch: 0, data: 8'h96, exp_pend: 4'b0001, exp_ch: 2'd0, exp_data: 8'h96};

    model_reset();
    @(negedge clk);
    check("reset_valid", 32'(out_valid), 0);
    check("reset_data", 32'(out_data), 0);
    check("reset_chan", 32'(out_ch), 0);
    check("reset_pend", 32'(out_pend), 0);
    check("reset_ovr", 32'(out_ovr), 0);
    tick();
    reset = 1'b1;
    repeat (2) tick();

    // Three simultaneous rising channels, served in round-robin order from channel 0.
    set_ch(0, 8'h11, 1'b1); set_ch(1, 8'h22, 1'b1); set_ch(3, 8'h44, 1'b1);
    repeat (3) tick();
    check("multi_pend", 32'(out_pend), 32'b1011);
    check("multi_nolate", 32'(out_valid), 0);
    tick();
    check("multi_w0", {out_valid, 6'd0, out_ch, out_data}, {1'b1, 6'd0, 2'd0, 8'h11});
    tick();
    check("multi_w1", {out_valid, 6'd0, out_ch, out_data}, {1'b1, 6'd0, 2'd1, 8'h22});
    tick();
    check("multi_w2", {out_valid, 6'd0, out_ch, out_data}, {1'b1, 6'd0, 2'd3, 8'h44});
    tick();
    check("multi_drop", 32'(out_valid), 0);
    avalid = '0;
    repeat (4) tick();
    // Pointer back at 0: channel 0 must beat channel 3.
    set_ch(0, 8'h0A, 1'b1); set_ch(3, 8'h3B, 1'b1);
    repeat (4) tick();
    check("ptr_w0", {out_valid, 6'd0, out_ch, out_data}, {1'b1, 6'd0, 2'd0, 8'h0A});
    tick();
    check("ptr_w1", {out_valid, 6'd0, out_ch, out_data}, {1'b1, 6'd0, 2'd3, 8'h3B});
    avalid = '0;
    repeat (4) tick();

    // Single-channel latency vectors.
    for (int i = 0; i < 4; i++) begin
      set_ch(vecs[i].ch, vecs[i].data, 1'b1);
      repeat (3) tick();
      check("vec_pend", 32'(out_pend), 32'(vecs[i].exp_pend));
      check("vec_early", 32'(out_valid), 0);
      tick();
      check("vec_word", {out_valid, 6'd0, out_ch, out_data},
            {1'b1, 6'd0, vecs[i].exp_ch, vecs[i].exp_data});
      tick();
      check("vec_single", 32'(out_valid), 0);
      avalid = '0;
      repeat (3) tick();
    end

    // Backpressure hold.
    ready = 1'b0;
    set_ch(1, 8'h5A, 1'b1);
    wait_valid("hold_timeout", 8);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_stable", {out_valid, 6'd0, out_ch, out_data}, {1'b1, 6'd0, 2'd1, 8'h5A});
    end
    ready = 1'b1;
    tick();
    check("hold_accept", 32'(out_valid), 0);
    avalid = '0;
    repeat (3) tick();

    // Reset while words are held and pending.
    ready = 1'b0;
    set_ch(0, 8'h10, 1'b1);
    wait_valid("rst_setup_timeout", 8);
    set_ch(1, 8'h21, 1'b1); set_ch(3, 8'h43, 1'b1);
    repeat (3) tick();
    check("rst_pend_before", 32'(out_pend), 32'b1010);
    avalid = '0;
    tick();
    reset = 1'b0;
    #1;
    check("rst_async", {out_valid, out_ch, out_data, out_pend, out_ovr}, 0);
    tick();
    check("rst_held", {out_valid, out_ch, out_data, out_pend, out_ovr}, 0);
    reset = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_silent", {out_valid, out_pend}, 0);
    end

    // Overwrite of an unread channel.
    ready = 1'b0;
    set_ch(2, 8'h77, 1'b1);
    wait_valid("ovr_setup_timeout", 8);
    set_ch(0, 8'h01, 1'b1);
    repeat (4) tick();
    check("ovr_first_pend", 32'(out_pend), 32'b0001);
    check("ovr_none_yet", 32'(out_ovr), 0);
    avalid[0] = 1'b0;
    repeat (2) tick();
    set_ch(0, 8'h02, 1'b1);
    repeat (4) tick();
    check("ovr_flag", 32'(out_ovr), 32'(OVR_EN));
    ready = 1'b1;
    tick();
    check("ovr_newest", {out_valid, 6'd0, out_ch, out_data}, {1'b1, 6'd0, 2'd0, 8'h02});
    tick();
    check("ovr_sticky", 32'(out_ovr), 32'(OVR_EN));
    oclear = 4'b0001;
    tick();
    oclear = '0;
    check("ovr_cleared", 32'(out_ovr), 0);
    avalid = '0;
    repeat (3) tick();

    // Toggle-mode instance: both edges of ch3 valid deliver a word.
    t_data[3*W +: W] = 8'h33; t_valid[3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (t_out_valid) begin words.push_back(t_out_data); wch.push_back(t_out_ch); end
    end
    t_data[3*W +: W] = 8'h66; t_valid[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (t_out_valid) begin words.push_back(t_out_data); wch.push_back(t_out_ch); end
    end
    check("tog_count", 32'(words.size()), 2);
    w0 = (words.size() > 0) ? words[0] : 8'hFF;
    w1 = (words.size() > 1) ? words[1] : 8'hFF;
    c0 = (wch.size() > 0) ? wch[0] : 2'd0;
    c1 = (wch.size() > 1) ? wch[1] : 2'd0;
    check("tog_w0", {c0, w0}, {2'd3, 8'h33});
    check("tog_w1", {c1, w1}, {2'd3, 8'h66});

    // Randomized traffic against the reference model.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) begin
        int idx;
        idx = $urandom_range(N - 1);
        avalid[idx] = ~avalid[idx];
      end
      adata  = $urandom;
      ready  = ($urandom_range(2) != 0);
      oclear = ($urandom_range(7) == 0) ? 4'($urandom) : '0;
      tick();
      check("rnd_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) check("rnd_word", {6'd0, out_ch, out_data}, {6'd0, 2'(m_ch), m_data});
      check("rnd_pend", 32'(out_pend), 32'(m_pend));
      check("rnd_ovr", 32'(out_ovr), 32'(m_ovr));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
